evt2_stream_gate: RTL

//  Buffers the raw EVT 2.0 word stream from the camera receiver and feeds the s00_axis input of the event-processing top.

---
 rtl/evt_pkg.sv | 19 +
 rtl/evt_sync_fifo.sv | 74 +++++++
 rtl/evt2_stream_gate.sv | 91 +++++++++
 3 files changed

// File: rtl/evt_pkg.sv
// EVT 2.0 word-type codes and field positions shared by the stream gate.
package evt_pkg;

  localparam int EVT2_TYPE_MSB = 31;
  localparam int EVT2_TYPE_LSB = 28;

  localparam logic [3:0] EVT2_CD_OFF      = 4'h0;
  localparam logic [3:0] EVT2_CD_ON       = 4'h1;
  localparam logic [3:0] EVT2_TIME_HIGH   = 4'h8;
  localparam logic [3:0] EVT2_EXT_TRIGGER = 4'hA;
  localparam logic [3:0] EVT2_OTHERS      = 4'hE;
  localparam logic [3:0] EVT2_CONTINUED   = 4'hF;

  // Only pixel (CD) events may be shed; every other word type carries state.
  function automatic logic evt2_is_cd(input logic [3:0] evt_type);
    return (evt_type == EVT2_CD_OFF) || (evt_type == EVT2_CD_ON);
  endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// Synchronous FIFO with registered read port; the output register always
// holds the head entry so data is stable while it is not popped.
module evt_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             push, pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = wr_en_i && !full_o;
  assign pop     = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A word written into the slot that becomes head this edge goes straight
    // to the output register, since the array still holds stale contents there.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      rd_data_d = wr_data_i;
    end else begin
      rd_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;

endmodule

// File: rtl/evt2_stream_gate.sv
// EVT 2.0 stream buffer that sheds CD events near full and never sheds
// timebase/trigger/tlast words. Optional drop counter: EVT2_DROP_CNT_EN.
module evt2_stream_gate
  import evt_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int DROP_RESERVE = 4
`ifdef EVT2_DROP_CNT_EN
  ,
  parameter int DROP_CNT_WIDTH = 32
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        drop_en_i,
  input  logic [31:0] s00_axis_tdata,
  input  logic        s00_axis_tlast,
  input  logic        s00_axis_tvalid,
  output logic        s00_axis_tready,
  output logic [31:0] m00_axis_tdata,
  output logic        m00_axis_tlast,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready
`ifdef EVT2_DROP_CNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
  input  logic                      drop_cnt_clr_i
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DROP_THRESH = CW'(FIFO_DEPTH - DROP_RESERVE);

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [32:0]   fifo_rd_data;
  logic          s_fire, drop_word, wr_en;

  assign s00_axis_tready = !fifo_full;
  assign s_fire          = s00_axis_tvalid && s00_axis_tready;

  // Threshold uses the registered count, so a pop in the same cycle does not
  // rescue a CD word.
  assign drop_word = s_fire && drop_en_i && !s00_axis_tlast
                   && evt2_is_cd(s00_axis_tdata[EVT2_TYPE_MSB:EVT2_TYPE_LSB])
                   && (fifo_count >= DROP_THRESH);
  assign wr_en     = s_fire && !drop_word;

  evt_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_data_i ({s00_axis_tlast, s00_axis_tdata}),
    .rd_en_i   (m00_axis_tready),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign m00_axis_tvalid = !fifo_empty;
  assign m00_axis_tlast  = fifo_rd_data[32];
  assign m00_axis_tdata  = fifo_rd_data[31:0];

`ifdef EVT2_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_cnt_clr_i) begin
      drop_cnt_d = drop_word ? DROP_CNT_WIDTH'(1) : '0;
    end else if (drop_word && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
